conv_layer: RTL and testbench
=============================

CONV_LAYER -- requirements
Module: conv_layer

Interface
- REQ-001 Parameter FM_WIDTH, default 8: input feature-map width and height (square).
- REQ-002 Parameter K_SIZE, default 3: kernel width and height (square).
- REQ-003 Parameter FRAC_BITS, default 0: arithmetic right shift applied to the accumulator before saturation.
- REQ-004 clk  input  1  sole clock; all state changes on rising edge.
- REQ-005 rst  input  1  reset, asynchronous and active-low.
- REQ-006 start  input  1  request to convolve the current input_fm with the current kernel.
- REQ-007 input_fm  input  32 signed x FM_WIDTH*FM_WIDTH  row-major input map.
- REQ-008 kernel  input  32 signed x K_SIZE*K_SIZE  row-major weights.
- REQ-009 bias  input  32 signed  added once per output pixel.
- REQ-010 busy  output  1  high from the first LOAD cycle through the last WRITE cycle.
- REQ-011 done  output  1  high while in DONE.
- REQ-012 output_fm  output  32 signed x OUT_W*OUT_W, OUT_W = FM_WIDTH-K_SIZE+1 (default 6x6=36)  row-major result.

Function
- REQ-013 States SHALL be IDLE, LOAD, MAC, WRITE, DONE.
- REQ-014 IDLE: start=1 -> LOAD; otherwise remain.
- REQ-015 LOAD, 1 cycle: snapshot input_fm, kernel and bias into internal registers; row=col=0; tap=0; accumulator=sign-extended bias; -> MAC.
- REQ-016 MAC: one tap per cycle, acc += in[(row+ky)*FM_WIDTH+col+kx] * k[ky*K_SIZE+kx], taps ordered ky-major; after tap K_SIZE*K_SIZE-1 -> WRITE.
- REQ-017 Products and accumulator SHALL be 64-bit signed; no intermediate truncation.
- REQ-018 WRITE, 1 cycle: output_fm[row*OUT_W+col] = saturate32(acc >>> FRAC_BITS), clamped to [-2^31, 2^31-1].
- REQ-019 After WRITE: if col<OUT_W-1, col+1; else if row<OUT_W-1, col=0 and row+1; reload acc with bias, tap=0, -> MAC; after the last pixel -> DONE.
- REQ-020 Latency: 1 + OUT_W^2*(K_SIZE^2+1) cycles from the start-sampling edge to done=1 (361 at default).
- REQ-021 start SHALL be ignored in LOAD, MAC and WRITE; input changes after LOAD SHALL not affect the result.
- REQ-022 DONE: done held high and output_fm held stable; start=1 -> LOAD (done falls the same edge); otherwise remain.
- REQ-023 Each output_fm element SHALL change only on its own WRITE cycle.

Reset
- REQ-024 rst=0 SHALL immediately force IDLE, done=0, busy=0, all output_fm=0, counters and accumulator=0, regardless of state.
- REQ-025 Reset mid-operation SHALL abort the run; no partial results survive; a new start SHALL be required.

Configuration
- REQ-026 Macro CONV_LAYER_RELU_EN defined: WRITE stores max(0, saturated value).
- REQ-027 Macro CONV_LAYER_RELU_EN undefined: WRITE stores the saturated value unmodified, negatives included; timing identical in both builds.

Structure
- REQ-028 Shared package cnn_pkg SHALL hold the 32-bit data and 64-bit accumulator typedefs, default FM/kernel dimension constants, and the conv state enum.
- REQ-029 Sub-module mac_unit (64-bit signed multiply-accumulate with clear-to-bias load and enable) SHALL be instantiated once; address generation and the FSM stay in conv_layer.

Verification
- REQ-030 input all 1, kernel all 1, bias 0 -> all 36 outputs = 9; done rises 361 cycles after start.
- REQ-031 kernel centre tap 1, others 0, input[i]=i, bias 5 -> output[r*6+c] = (r+1)*8+c+1+5.
- REQ-032 input all 0x7FFFFFFF, kernel all 2 -> all outputs 0x7FFFFFFF; kernel all -2 -> 0x80000000 without RELU_EN, 0 with it.
- REQ-033 rst=0 pulsed at cycle 100 of a run -> outputs 0, done=0, busy=0 immediately; a following start yields correct full results.
- REQ-034 start re-pulsed and input_fm changed mid-run -> results match the LOAD-time snapshot; completion time unchanged.
- REQ-035 start held high through DONE -> exactly one new run per DONE exit; done low for its duration.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types, default dimensions, FSM encoding and arithmetic helpers for the CNN blocks.
package cnn_pkg;

  typedef logic signed [31:0] data_t;
  typedef logic signed [63:0] acc_t;

  localparam int FM_WIDTH_DEF = 8;
  localparam int K_SIZE_DEF   = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MAC   = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } conv_state_t;

  localparam acc_t SAT_MAX = 64'sh0000_0000_7FFF_FFFF;
  localparam acc_t SAT_MIN = 64'shFFFF_FFFF_8000_0000;

  function automatic data_t saturate32(input acc_t v);
    if (v > SAT_MAX) begin
      return 32'sh7FFF_FFFF;
    end else if (v < SAT_MIN) begin
      return 32'sh8000_0000;
    end else begin
      return data_t'(v[31:0]);
    end
  endfunction

  function automatic data_t relu32(input data_t v);
    if (v < 32'sd0) begin
      return 32'sd0;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/mac_unit.sv
// 64-bit signed multiply-accumulate; load replaces the sum with the sign-extended bias.
module mac_unit
  import cnn_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  en,
  input  data_t a,
  input  data_t b,
  input  data_t bias,
  output acc_t  acc
);

  acc_t a_ext_s;
  acc_t b_ext_s;
  acc_t bias_ext_s;
  acc_t acc_r;

  // Full-width operand extension so the product never truncates.
  always_comb begin
    a_ext_s    = {{32{a[31]}}, a};
    b_ext_s    = {{32{b[31]}}, b};
    bias_ext_s = {{32{bias[31]}}, bias};
  end

  // Accumulator register: load has priority over accumulate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r <= 64'sd0;
    end else if (load) begin
      acc_r <= bias_ext_s;
    end else if (en) begin
      acc_r <= acc_r + (a_ext_s * b_ext_s);
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/conv_layer.sv
// Valid-mode 2-D convolution, one kernel tap per cycle, bias + shift + saturation per pixel.
// Optional macro CONV_LAYER_RELU_EN clamps stored pixels at zero.
module conv_layer
  import cnn_pkg::*;
#(
  parameter  int FM_WIDTH  = FM_WIDTH_DEF,
  parameter  int K_SIZE    = K_SIZE_DEF,
  parameter  int FRAC_BITS = 0,
  localparam int OUT_W     = FM_WIDTH - K_SIZE + 1
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  start,
  input  data_t input_fm  [FM_WIDTH*FM_WIDTH],
  input  data_t kernel    [K_SIZE*K_SIZE],
  input  data_t bias,
  output logic  busy,
  output logic  done,
  output data_t output_fm [OUT_W*OUT_W]
);

  localparam int CNT_W  = (FM_WIDTH > 1) ? $clog2(FM_WIDTH) : 1;
  localparam int K_W    = (K_SIZE > 1) ? $clog2(K_SIZE) : 1;
  localparam int IN_IW  = (FM_WIDTH * FM_WIDTH > 1) ? $clog2(FM_WIDTH * FM_WIDTH) : 1;
  localparam int K_IW   = (K_SIZE * K_SIZE > 1) ? $clog2(K_SIZE * K_SIZE) : 1;
  localparam int OUT_IW = (OUT_W * OUT_W > 1) ? $clog2(OUT_W * OUT_W) : 1;

  conv_state_t        state_r;
  logic [CNT_W-1:0]   row_r;
  logic [CNT_W-1:0]   col_r;
  logic [K_W-1:0]     ky_r;
  logic [K_W-1:0]     kx_r;
  data_t              in_r [FM_WIDTH*FM_WIDTH];
  data_t              k_r  [K_SIZE*K_SIZE];
  data_t              bias_r;

  logic [IN_IW-1:0]   in_idx_s;
  logic [K_IW-1:0]    k_idx_s;
  logic [OUT_IW-1:0]  out_idx_s;
  logic               mac_load_s;
  logic               mac_en_s;
  data_t              mac_bias_s;
  acc_t               acc_s;
  acc_t               shifted_s;
  data_t              sat_s;
  data_t              wr_s;

  // Tap addressing, MAC control and the write-back value.
  always_comb begin
    in_idx_s   = IN_IW'((int'(row_r) + int'(ky_r)) * FM_WIDTH + int'(col_r) + int'(kx_r));
    k_idx_s    = K_IW'(int'(ky_r) * K_SIZE + int'(kx_r));
    out_idx_s  = OUT_IW'(int'(row_r) * OUT_W + int'(col_r));
    mac_en_s   = (state_r == ST_MAC);
    mac_load_s = (state_r == ST_LOAD) || (state_r == ST_WRITE);
    // The snapshot lands on the same edge as the first bias load, so LOAD feeds bias directly.
    if (state_r == ST_LOAD) begin
      mac_bias_s = bias;
    end else begin
      mac_bias_s = bias_r;
    end
    shifted_s = acc_s >>> FRAC_BITS;
    sat_s     = saturate32(shifted_s);
`ifdef CONV_LAYER_RELU_EN
    wr_s = relu32(sat_s);
`else
    wr_s = sat_s;
`endif
  end

  mac_unit u_mac (
    .clk  (clk),
    .rst  (rst),
    .load (mac_load_s),
    .en   (mac_en_s),
    .a    (in_r[in_idx_s]),
    .b    (k_r[k_idx_s]),
    .bias (mac_bias_s),
    .acc  (acc_s)
  );

  // Control FSM with snapshot registers, pixel/tap counters and the result array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      row_r   <= '0;
      col_r   <= '0;
      ky_r    <= '0;
      kx_r    <= '0;
      bias_r  <= 32'sd0;
      for (int i = 0; i < FM_WIDTH * FM_WIDTH; i++) in_r[i] <= 32'sd0;
      for (int i = 0; i < K_SIZE * K_SIZE; i++) k_r[i] <= 32'sd0;
      for (int i = 0; i < OUT_W * OUT_W; i++) output_fm[i] <= 32'sd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_LOAD;
            busy    <= 1'b1;
          end
        end
        ST_LOAD: begin
          in_r    <= input_fm;
          k_r     <= kernel;
          bias_r  <= bias;
          row_r   <= '0;
          col_r   <= '0;
          ky_r    <= '0;
          kx_r    <= '0;
          state_r <= ST_MAC;
        end
        ST_MAC: begin
          if (kx_r == K_W'(K_SIZE - 1)) begin
            kx_r <= '0;
            if (ky_r == K_W'(K_SIZE - 1)) begin
              ky_r    <= '0;
              state_r <= ST_WRITE;
            end else begin
              ky_r <= ky_r + K_W'(1);
            end
          end else begin
            kx_r <= kx_r + K_W'(1);
          end
        end
        ST_WRITE: begin
          output_fm[out_idx_s] <= wr_s;
          if (col_r != CNT_W'(OUT_W - 1)) begin
            col_r   <= col_r + CNT_W'(1);
            state_r <= ST_MAC;
          end else if (row_r != CNT_W'(OUT_W - 1)) begin
            col_r   <= '0;
            row_r   <= row_r + CNT_W'(1);
            state_r <= ST_MAC;
          end else begin
            state_r <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        ST_DONE: begin
          if (start) begin
            state_r <= ST_LOAD;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer.sv
// Scoreboard bench for conv_layer: stimulus queues expected maps, a monitor checks them on done.
module tb_conv_layer;
  import cnn_pkg::*;

  localparam int N_IN  = 64;
  localparam int N_K   = 9;
  localparam int N_OUT = 36;
  localparam int LAT   = 361;

  logic  clk = 1'b0;
  logic  rst;
  logic  start;
  data_t input_fm  [N_IN];
  data_t kernel    [N_K];
  data_t bias;
  logic  busy;
  logic  done;
  data_t output_fm [N_OUT];

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  logic  done_q  = 1'b0;
  string name_q[$];
  int    cyc_q[$];
  data_t val_q[$];
  data_t exp_vals [N_OUT];

  conv_layer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .input_fm  (input_fm),
    .kernel    (kernel),
    .bias      (bias),
    .busy      (busy),
    .done      (done),
    .output_fm (output_fm)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic data_t tb_relu(input data_t v);
`ifdef CONV_LAYER_RELU_EN
    return (v < 32'sd0) ? 32'sd0 : v;
`else
    return v;
`endif
  endfunction

  task automatic check(input string nm, input logic signed [63:0] got, input logic signed [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic fill(input data_t vi, input data_t vk, input data_t vb);
    for (int i = 0; i < N_IN; i++) input_fm[i] = vi;
    for (int i = 0; i < N_K; i++) kernel[i] = vk;
    bias = vb;
  endtask

  task automatic fill_centre();
    for (int i = 0; i < N_IN; i++) input_fm[i] = i;
    for (int i = 0; i < N_K; i++) kernel[i] = 32'sd0;
    kernel[4] = 32'sd1;
    bias = 32'sd5;
  endtask

  task automatic exp_const(input data_t v);
    for (int i = 0; i < N_OUT; i++) exp_vals[i] = v;
  endtask

  task automatic exp_centre();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        exp_vals[r*6+c] = (r + 1) * 8 + c + 1 + 5;
  endtask

  task automatic push(input string nm, input int ec);
    name_q.push_back(nm);
    cyc_q.push_back(ec);
    for (int i = 0; i < N_OUT; i++) val_q.push_back(exp_vals[i]);
  endtask

  task automatic do_start(input string nm, input bit hold, output int s);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    s = cyc;
    check({nm, "_busy_rise"}, busy, 1);
    check({nm, "_done_low"}, done, 0);
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (name_q.size() != 0 && k < 1000) begin
      @(posedge clk);
      k++;
    end
    if (name_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending results, want 0", nm, name_q.size());
      name_q.delete();
      cyc_q.delete();
      val_q.delete();
    end
  endtask

  task automatic check_all_zero(input string nm);
    int nz;
    nz = 0;
    for (int i = 0; i < N_OUT; i++) if (output_fm[i] !== 32'sd0) nz++;
    check(nm, nz, 0);
  endtask

  // Monitor: on each done rise, pop one expected map and compare timing and pixels.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (done && !done_q) begin
        if (name_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done rise at cycle %0d, want none", cyc);
        end else begin
          string nm;
          int    ec;
          nm = name_q.pop_front();
          ec = cyc_q.pop_front();
          check({nm, "_latency"}, cyc, ec);
          check({nm, "_busy_at_done"}, busy, 0);
          for (int i = 0; i < N_OUT; i++) begin
            data_t ev;
            ev = val_q.pop_front();
            check($sformatf("%s_px%0d", nm, i), output_fm[i], ev);
          end
        end
      end
      done_q = done;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by cycle %0d, want finish", cyc);
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    int s;
    rst   = 1'b1;
    start = 1'b0;
    fill(32'sd0, 32'sd0, 32'sd0);
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check_all_zero("reset_outputs_nonzero");
    @(negedge clk);
    rst = 1'b1;

    fill(32'sd1, 32'sd1, 32'sd0);
    exp_const(32'sd9);
    do_start("ones", 1'b0, s);
    push("ones", s + LAT);
    wait_idle("ones");

    fill_centre();
    exp_centre();
    do_start("centre", 1'b0, s);
    push("centre", s + LAT);
    wait_idle("centre");

    fill(32'sh7FFF_FFFF, 32'sd2, 32'sd0);
    exp_const(32'sh7FFF_FFFF);
    do_start("sat_pos", 1'b0, s);
    push("sat_pos", s + LAT);
    wait_idle("sat_pos");

    fill(32'sh7FFF_FFFF, -32'sd2, 32'sd0);
    exp_const(tb_relu(32'sh8000_0000));
    do_start("sat_neg", 1'b0, s);
    push("sat_neg", s + LAT);
    wait_idle("sat_neg");

    fill(32'sd1, -32'sd1, -32'sd3);
    exp_const(tb_relu(-32'sd12));
    do_start("negative", 1'b0, s);
    push("negative", s + LAT);
    wait_idle("negative");

    // Re-pulsed start and changed inputs mid-run must not disturb the snapshot.
    fill_centre();
    exp_centre();
    do_start("midrun", 1'b0, s);
    push("midrun", s + LAT);
    repeat (50) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    fill(32'sh7FFF_FFFF, 32'sd2, 32'sd1000);
    @(negedge clk);
    start = 1'b0;
    wait_idle("midrun");
    repeat (5) @(posedge clk);
    #1;
    check("midrun_done_held", done, 1);
    check("midrun_no_extra_run", busy, 0);

    // Asynchronous reset mid-run clears everything and requires a fresh start.
    fill(32'sd1, 32'sd1, 32'sd0);
    do_start("abort", 1'b0, s);
    repeat (99) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check_all_zero("abort_outputs_nonzero");
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_stays_idle", busy, 0);
    fill_centre();
    exp_centre();
    do_start("after_abort", 1'b0, s);
    push("after_abort", s + LAT);
    wait_idle("after_abort");

    // start held through DONE: exactly one chained run, fresh snapshot.
    fill(32'sd1, -32'sd1, -32'sd3);
    exp_const(tb_relu(-32'sd12));
    do_start("held", 1'b1, s);
    push("held_a", s + LAT);
    repeat (2) @(negedge clk);
    fill(32'sd1, 32'sd1, 32'sd0);
    exp_const(32'sd9);
    push("held_b", s + 2 * LAT + 1);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < s + LAT + 1);
    check("held_done_falls", done, 0);
    check("held_busy_again", busy, 1);
    @(negedge clk);
    start = 1'b0;
    wait_idle("held");
    repeat (5) @(posedge clk);
    #1;
    check("held_done_held", done, 1);
    check("held_single_rerun", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
